gen_fip_dot_prod_ctrl: RTL and testbench

Sequential dot-product controller for signed fixed-point vectors. It is the initiator side of the fixed-point arithmetic start/done protocol. It takes element pairs from upstream over a valid/ready handshake and issues one `i_start_pls`/`i_num1`/`i_num2` request per pair to an external `gen_fip_sign_mult`. It collects the `o_done_pls`/`o_res` responses and accumulates them. After `VEC_LEN` products it emits the sum with a done pulse. It sits between a vector source (e.g. a coefficient/sample buffer) and the shared multiplier.

---
 rtl/gen_fip_dot_prod_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_gen_fip_dot_prod_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_fip_dot_prod_ctrl.sv
// gen_fip_dot_prod_ctrl
// Sequential signed fixed-point dot-product controller. It takes element pairs
// over a valid/ready handshake and sends one request per pair to an external
// start/done multiplier. It sums the returned products and presents the total
// with a one-cycle done pulse.
// Optional feature macro: GEN_FIP_DOT_SAT_EN. When it is defined, the
// accumulator saturates and o_sat is sticky. When it is undefined, the sum
// wraps modulo 2^RES_W and o_sat is tied low.
module gen_fip_dot_prod_ctrl #(
    parameter int IN_INT_W     = 1,
    parameter int IN_FRACT_W   = 5,
    parameter int VEC_LEN      = 4,
    parameter int ACC_INT_W    = 3,
    parameter int MULT_TIMEOUT = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sw_rst,
    input  logic                                i_start_pls,
    input  logic                                i_elem_vld,
    output logic                                o_elem_rdy,
    input  logic [IN_INT_W+IN_FRACT_W-1:0]      i_num1,
    input  logic [IN_INT_W+IN_FRACT_W-1:0]      i_num2,
    output logic                                o_mult_start_pls,
    output logic [IN_INT_W+IN_FRACT_W-1:0]      o_mult_num1,
    output logic [IN_INT_W+IN_FRACT_W-1:0]      o_mult_num2,
    input  logic                                i_mult_done_pls,
    input  logic [2*(IN_INT_W+IN_FRACT_W)-1:0]  i_mult_res,
    output logic                                o_done_pls,
    output logic [ACC_INT_W+2*IN_FRACT_W-1:0]   o_res,
    output logic                                o_busy,
    output logic                                o_sat,
    output logic                                o_err_pls
);

    localparam int IN_W   = IN_INT_W + IN_FRACT_W;
    localparam int PROD_W = 2 * IN_W;
    localparam int RES_W  = ACC_INT_W + 2 * IN_FRACT_W;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int TMO_W  = $clog2(MULT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ELEM,
        ISSUE,
        WAIT_RES,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   elem_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RES_W-1:0]   acc;
    logic [RES_W-1:0]   acc_upd;
    logic [RES_W-1:0]   prod_sext;
    logic               acc_en;
    logic               last_elem;
    logic               start_acc;

    assign start_acc        = (state == IDLE) && i_start_pls;
    assign last_elem        = (elem_cnt == CNT_W'(VEC_LEN - 1));
    assign o_elem_rdy       = (state == WAIT_ELEM);
    assign o_mult_start_pls = (state == ISSUE);
    assign prod_sext        = RES_W'($signed(i_mult_res));

`ifdef GEN_FIP_DOT_SAT_EN
    logic [RES_W:0] sum_ext;
    logic           ovf;
    logic           sat_q;

    assign sum_ext = {prod_sext[RES_W-1], prod_sext} + {acc[RES_W-1], acc};
    assign ovf     = sum_ext[RES_W] ^ sum_ext[RES_W-1];
    assign acc_upd = !ovf           ? sum_ext[RES_W-1:0] :
                     sum_ext[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} :
                                      {1'b0, {(RES_W-1){1'b1}}};
    assign o_sat   = sat_q;

    // Sticky saturation flag, cleared when a new vector starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (sw_rst || start_acc) begin
            sat_q <= 1'b0;
        end else if (acc_en && ovf) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign acc_upd = acc + prod_sext;
    assign o_sat   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (sw_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accumulate strobe and the timeout error pulse
    always_comb begin
        state_nxt = state;
        acc_en    = 1'b0;
        o_err_pls = 1'b0;
        case (state)
            IDLE: begin
                if (i_start_pls) state_nxt = WAIT_ELEM;
            end
            WAIT_ELEM: begin
                if (i_elem_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (i_mult_done_pls) begin
                    acc_en    = 1'b1;
                    state_nxt = last_elem ? DONE : WAIT_ELEM;
                end else begin
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (i_mult_done_pls) begin
                    acc_en    = 1'b1;
                    state_nxt = last_elem ? DONE : WAIT_ELEM;
                end else if (tmo_cnt == TMO_W'(MULT_TIMEOUT)) begin
                    o_err_pls = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operands, accumulator, counters, result and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_mult_num1 <= '0;
            o_mult_num2 <= '0;
            acc         <= '0;
            elem_cnt    <= '0;
            tmo_cnt     <= '0;
            o_res       <= '0;
            o_done_pls  <= 1'b0;
            o_busy      <= 1'b0;
        end else if (sw_rst) begin
            o_mult_num1 <= '0;
            o_mult_num2 <= '0;
            acc         <= '0;
            elem_cnt    <= '0;
            tmo_cnt     <= '0;
            o_res       <= '0;
            o_done_pls  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_done_pls <= (state == DONE);
            if (state == DONE) begin
                o_res <= acc;
            end
            if (start_acc) begin
                o_busy <= 1'b1;
            end else if (o_done_pls || o_err_pls) begin
                o_busy <= 1'b0;
            end
            if ((state == WAIT_ELEM) && i_elem_vld) begin
                o_mult_num1 <= i_num1;
                o_mult_num2 <= i_num2;
            end
            if (start_acc) begin
                tmo_cnt <= '0;
            end else if (state == ISSUE) begin
                tmo_cnt <= TMO_W'(1);
            end else if (state == WAIT_RES) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (start_acc) begin
                acc      <= '0;
                elem_cnt <= '0;
            end else if (acc_en) begin
                acc <= acc_upd;
                if (!last_elem) begin
                    elem_cnt <= elem_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_fip_dot_prod_ctrl.sv
// Testbench for gen_fip_dot_prod_ctrl: directed and randomized vectors checked
// against an integer-arithmetic dot-product model, with a programmable-latency
// multiplier responder standing in for gen_fip_sign_mult.
module tb_gen_fip_dot_prod_ctrl;

    localparam int IN_INT_W     = 1;
    localparam int IN_FRACT_W   = 5;
    localparam int VEC_LEN      = 4;
    localparam int ACC_INT_W    = 3;
    localparam int MULT_TIMEOUT = 15;
    localparam int IN_W         = IN_INT_W + IN_FRACT_W;
    localparam int PROD_W       = 2 * IN_W;
    localparam int RES_W        = ACC_INT_W + 2 * IN_FRACT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sw_rst;
    logic              i_start_pls;
    logic              i_elem_vld;
    logic              o_elem_rdy;
    logic [IN_W-1:0]   i_num1;
    logic [IN_W-1:0]   i_num2;
    logic              o_mult_start_pls;
    logic [IN_W-1:0]   o_mult_num1;
    logic [IN_W-1:0]   o_mult_num2;
    logic              i_mult_done_pls;
    logic [PROD_W-1:0] i_mult_res;
    logic              o_done_pls;
    logic [RES_W-1:0]  o_res;
    logic              o_busy;
    logic              o_sat;
    logic              o_err_pls;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [IN_W-1:0] va [VEC_LEN];
    logic signed [IN_W-1:0] vb [VEC_LEN];
    logic [RES_W-1:0]       last_expected = '0;

    // Multiplier responder state
    int   mult_lat   = 0;
    int   mult_limit = 1 << 30;
    int   start_cnt  = 0;
    int   mult_wait  = 0;
    logic mult_done_q = 1'b0;

    gen_fip_dot_prod_ctrl #(
        .IN_INT_W(IN_INT_W), .IN_FRACT_W(IN_FRACT_W), .VEC_LEN(VEC_LEN),
        .ACC_INT_W(ACC_INT_W), .MULT_TIMEOUT(MULT_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst), .i_start_pls(i_start_pls),
        .i_elem_vld(i_elem_vld), .o_elem_rdy(o_elem_rdy),
        .i_num1(i_num1), .i_num2(i_num2),
        .o_mult_start_pls(o_mult_start_pls), .o_mult_num1(o_mult_num1),
        .o_mult_num2(o_mult_num2), .i_mult_done_pls(i_mult_done_pls),
        .i_mult_res(i_mult_res), .o_done_pls(o_done_pls), .o_res(o_res),
        .o_busy(o_busy), .o_sat(o_sat), .o_err_pls(o_err_pls)
    );

    always #5 clk = ~clk;

    // Multiplier product and response pulse (zero latency answers combinationally)
    always_comb begin
        int p;
        p = int'($signed(o_mult_num1)) * int'($signed(o_mult_num2));
        i_mult_res = p[PROD_W-1:0];
        if (mult_lat == 0) begin
            i_mult_done_pls = o_mult_start_pls && (start_cnt < mult_limit);
        end else begin
            i_mult_done_pls = mult_done_q;
        end
    end

    // Multiplier latency pipeline and request counter
    always @(posedge clk) begin
        mult_done_q <= 1'b0;
        if (mult_wait == 1) begin
            mult_done_q <= 1'b1;
            mult_wait   <= 0;
        end else if (mult_wait > 1) begin
            mult_wait <= mult_wait - 1;
        end
        if (o_mult_start_pls) begin
            start_cnt <= start_cnt + 1;
            if (mult_lat > 0 && start_cnt < mult_limit) begin
                if (mult_lat == 1) mult_done_q <= 1'b1;
                else               mult_wait   <= mult_lat - 1;
            end
        end
    end

    // Reference: exact integer dot product, clamped per step or wrapped at the end
    function automatic void model_dot(output logic [RES_W-1:0] r, output logic s);
        longint acc;
        longint one;
        longint maxv;
        longint minv;
        one  = 1;
        maxv = (one << (RES_W - 1)) - 1;
        minv = -(one << (RES_W - 1));
        acc  = 0;
        s    = 1'b0;
        for (int i = 0; i < VEC_LEN; i++) begin
            acc = acc + longint'(va[i]) * longint'(vb[i]);
`ifdef GEN_FIP_DOT_SAT_EN
            if (acc > maxv) begin
                acc = maxv;
                s   = 1'b1;
            end else if (acc < minv) begin
                acc = minv;
                s   = 1'b1;
            end
`endif
        end
        r = acc[RES_W-1:0];
    endfunction

    task automatic fill_random();
        logic [31:0] rv;
        for (int i = 0; i < VEC_LEN; i++) begin
            rv = $urandom;
            va[i] = rv[IN_W-1:0];
            vb[i] = rv[IN_W+15:16];
        end
    endtask

    task automatic fill_const(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        for (int i = 0; i < VEC_LEN; i++) begin
            va[i] = a;
            vb[i] = b;
        end
    endtask

    // Runs one vector and reports what was observed; k counts from the first WAIT_ELEM cycle
    task automatic drive_vector(input bit toggle, input bit extra_start,
                                output bit got_done, output int done_k,
                                output logic [RES_W-1:0] res, output logic sat,
                                output int starts, output int op_errs,
                                output bit err_seen, output int err_k,
                                output logic busy_first, output logic busy_after);
        int              idx;
        bit              pend;
        bit              fin;
        logic [IN_W-1:0] l1;
        logic [IN_W-1:0] l2;
        got_done = 0; done_k = -1; err_seen = 0; err_k = -1;
        res = '0; sat = 1'b0; starts = 0; op_errs = 0;
        busy_first = 1'b0; busy_after = 1'bx;
        idx = 0; pend = 0; fin = 0; l1 = '0; l2 = '0;
        @(negedge clk);
        i_start_pls = 1'b1;
        @(negedge clk);
        i_start_pls = 1'b0;
        busy_first  = o_busy;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            if (got_done || err_seen) begin
                busy_after = o_busy;
                fin        = 1;
            end else begin
                i_start_pls = extra_start && (k == 4);
                if (o_mult_start_pls) begin
                    starts++;
                    l1 = o_mult_num1;
                    l2 = o_mult_num2;
                    if (starts <= VEC_LEN) begin
                        if (l1 !== va[starts-1] || l2 !== vb[starts-1]) op_errs++;
                    end
                    pend = !i_mult_done_pls;
                end else if (pend) begin
                    if (o_mult_num1 !== l1 || o_mult_num2 !== l2) op_errs++;
                    if (i_mult_done_pls) pend = 0;
                end
                if (o_done_pls) begin
                    got_done = 1;
                    done_k   = k;
                    res      = o_res;
                    sat      = o_sat;
                end
                if (o_err_pls) begin
                    err_seen = 1;
                    err_k    = k;
                    res      = o_res;
                end
                i_elem_vld = toggle ? (k % 2 == 1) : 1'b1;
                i_num1     = va[(idx < VEC_LEN) ? idx : 0];
                i_num2     = vb[(idx < VEC_LEN) ? idx : 0];
                if (o_elem_rdy && i_elem_vld) idx++;
            end
        end
        i_elem_vld  = 1'b0;
        i_start_pls = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({o_elem_rdy, o_mult_start_pls, o_done_pls, o_busy, o_sat, o_err_pls} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got=%b want=000000",
                     {o_elem_rdy, o_mult_start_pls, o_done_pls, o_busy, o_sat, o_err_pls});
        end
        n_checks++;
        if ({o_mult_num1, o_mult_num2, o_res} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data num1=%h num2=%h res=%h want all 0",
                     o_mult_num1, o_mult_num2, o_res);
        end
    endtask

    task automatic test_directed();
        logic [IN_W-1:0]  da [3];
        logic [IN_W-1:0]  db [3];
        logic [RES_W-1:0] want_res [3];
        logic             want_sat [3];
        bit got_done, err_seen;
        int done_k, starts, op_errs, err_k;
        logic [RES_W-1:0] res;
        logic sat, busy_first, busy_after;
        da[0] = 6'b010000; db[0] = 6'b010000; want_res[0] = 13'h0400; want_sat[0] = 1'b0;
        da[1] = 6'b100000; db[1] = 6'b011111; want_res[1] = 13'h1080; want_sat[1] = 1'b0;
        da[2] = 6'b100000; db[2] = 6'b100000;
`ifdef GEN_FIP_DOT_SAT_EN
        want_res[2] = 13'h0FFF; want_sat[2] = 1'b1;
`else
        want_res[2] = 13'h1000; want_sat[2] = 1'b0;
`endif
        mult_lat = 0;
        for (int v = 0; v < 3; v++) begin
            fill_const(da[v], db[v]);
            drive_vector(1'b0, 1'b0, got_done, done_k, res, sat, starts, op_errs,
                         err_seen, err_k, busy_first, busy_after);
            last_expected = want_res[v];
            n_checks++;
            if (res !== want_res[v] || !got_done) begin
                n_fail++;
                $display("[TB] FAIL directed_res v=%0d got=%h done=%0b want=%h", v, res, got_done, want_res[v]);
            end
            n_checks++;
            if (sat !== want_sat[v]) begin
                n_fail++;
                $display("[TB] FAIL directed_sat v=%0d got=%b want=%b", v, sat, want_sat[v]);
            end
            n_checks++;
            if (done_k !== 2 * VEC_LEN + 1) begin
                n_fail++;
                $display("[TB] FAIL directed_latency v=%0d got=%0d want=%0d", v, done_k, 2 * VEC_LEN + 1);
            end
            n_checks++;
            if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL directed_busy v=%0d first=%b after=%b want 1/0", v, busy_first, busy_after);
            end
            n_checks++;
            if (starts !== VEC_LEN || op_errs !== 0) begin
                n_fail++;
                $display("[TB] FAIL directed_issue v=%0d starts=%0d operr=%0d want %0d/0", v, starts, op_errs, VEC_LEN);
            end
        end
    endtask

    task automatic test_latency();
        bit got_done, err_seen;
        int done_k, starts, op_errs, err_k;
        logic [RES_W-1:0] res, want;
        logic sat, want_sat, busy_first, busy_after;
        mult_lat = 3;
        for (int v = 0; v < 2; v++) begin
            if (v == 0) fill_const(6'b010000, 6'b010000);
            else        fill_const(6'b100000, 6'b011111);
            model_dot(want, want_sat);
            drive_vector(1'b1, 1'b1, got_done, done_k, res, sat, starts, op_errs,
                         err_seen, err_k, busy_first, busy_after);
            last_expected = want;
            n_checks++;
            if (res !== want || !got_done) begin
                n_fail++;
                $display("[TB] FAIL latency_res v=%0d got=%h done=%0b want=%h", v, res, got_done, want);
            end
            n_checks++;
            if (starts !== VEC_LEN || op_errs !== 0) begin
                n_fail++;
                $display("[TB] FAIL latency_issue v=%0d starts=%0d operr=%0d want %0d/0", v, starts, op_errs, VEC_LEN);
            end
        end
        mult_lat = 0;
    endtask

    task automatic test_random();
        bit got_done, err_seen;
        int done_k, starts, op_errs, err_k;
        logic [RES_W-1:0] res, want;
        logic sat, want_sat, busy_first, busy_after;
        bit toggle, extra;
        for (int v = 0; v < 10; v++) begin
            fill_random();
            mult_lat = $urandom_range(0, 4);
            toggle   = 1'($urandom_range(0, 1));
            extra    = 1'($urandom_range(0, 1));
            model_dot(want, want_sat);
            drive_vector(toggle, extra, got_done, done_k, res, sat, starts, op_errs,
                         err_seen, err_k, busy_first, busy_after);
            last_expected = want;
            n_checks++;
            if (res !== want || sat !== want_sat || !got_done) begin
                n_fail++;
                $display("[TB] FAIL random_res v=%0d lat=%0d got=%h sat=%b done=%0b want=%h sat=%b",
                         v, mult_lat, res, sat, got_done, want, want_sat);
            end
            n_checks++;
            if (starts !== VEC_LEN || op_errs !== 0 || err_seen) begin
                n_fail++;
                $display("[TB] FAIL random_issue v=%0d starts=%0d operr=%0d err=%0b want %0d/0/0",
                         v, starts, op_errs, err_seen, VEC_LEN);
            end
        end
        mult_lat = 0;
    endtask

    task automatic test_timeout();
        bit got_done, err_seen;
        int done_k, starts, op_errs, err_k;
        logic [RES_W-1:0] res;
        logic sat, busy_first, busy_after;
        fill_random();
        mult_lat   = 0;
        mult_limit = start_cnt + 1;
        drive_vector(1'b0, 1'b0, got_done, done_k, res, sat, starts, op_errs,
                     err_seen, err_k, busy_first, busy_after);
        mult_limit = 1 << 30;
        n_checks++;
        if (!err_seen || err_k !== 3 + MULT_TIMEOUT) begin
            n_fail++;
            $display("[TB] FAIL timeout_err seen=%0b cycle=%0d want cycle %0d", err_seen, err_k, 3 + MULT_TIMEOUT);
        end
        n_checks++;
        if (got_done || busy_after !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timeout_done done=%0b busy_after=%b want 0/0", got_done, busy_after);
        end
        n_checks++;
        if (res !== last_expected || o_res !== last_expected) begin
            n_fail++;
            $display("[TB] FAIL timeout_res at_err=%h now=%h want=%h", res, o_res, last_expected);
        end
        n_checks++;
        if (starts !== 2 || op_errs !== 0) begin
            n_fail++;
            $display("[TB] FAIL timeout_issue starts=%0d operr=%0d want 2/0", starts, op_errs);
        end
    endtask

    task automatic test_sw_rst();
        fill_random();
        @(negedge clk);
        i_start_pls = 1'b1;
        @(negedge clk);
        i_start_pls = 1'b0;
        i_elem_vld  = 1'b1;
        i_num1      = va[0];
        i_num2      = vb[0];
        repeat (3) @(negedge clk);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst     = 1'b0;
        i_elem_vld = 1'b0;
        n_checks++;
        if ({o_busy, o_elem_rdy, o_mult_start_pls, o_done_pls, o_err_pls} !== 5'b0 || o_res !== '0) begin
            n_fail++;
            $display("[TB] FAIL sw_rst flags=%b res=%h want 00000/0",
                     {o_busy, o_elem_rdy, o_mult_start_pls, o_done_pls, o_err_pls}, o_res);
        end
        last_expected = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_abort();
        bit got_done, err_seen, reached;
        int done_k, starts, op_errs, err_k, seen;
        logic [RES_W-1:0] res, want;
        logic sat, want_sat, busy_first, busy_after;
        fill_random();
        mult_lat = 3;
        seen     = 0;
        reached  = 0;
        @(negedge clk);
        i_start_pls = 1'b1;
        @(negedge clk);
        i_start_pls = 1'b0;
        i_elem_vld  = 1'b1;
        for (int k = 0; k < 100 && !reached; k++) begin
            if (o_mult_start_pls) seen++;
            i_num1 = va[seen < VEC_LEN ? seen : 0];
            i_num2 = vb[seen < VEC_LEN ? seen : 0];
            if (seen == 2) reached = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("[TB] FAIL abort_reach issues=%0d want 2", seen);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_elem_rdy, o_mult_start_pls, o_done_pls, o_busy, o_sat, o_err_pls} !== 6'b0 ||
            {o_mult_num1, o_mult_num2, o_res} !== '0) begin
            n_fail++;
            $display("[TB] FAIL abort_async flags=%b num1=%h num2=%h res=%h want all 0",
                     {o_elem_rdy, o_mult_start_pls, o_done_pls, o_busy, o_sat, o_err_pls},
                     o_mult_num1, o_mult_num2, o_res);
        end
        i_elem_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        fill_random();
        model_dot(want, want_sat);
        drive_vector(1'b0, 1'b0, got_done, done_k, res, sat, starts, op_errs,
                     err_seen, err_k, busy_first, busy_after);
        n_checks++;
        if (res !== want || sat !== want_sat || !got_done) begin
            n_fail++;
            $display("[TB] FAIL abort_next got=%h sat=%b done=%0b want=%h sat=%b",
                     res, sat, got_done, want, want_sat);
        end
        mult_lat = 0;
    endtask

    initial begin
        rst = 1'b1; sw_rst = 1'b0; i_start_pls = 1'b0; i_elem_vld = 1'b0;
        i_num1 = '0; i_num2 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_directed();
        test_latency();
        test_random();
        test_timeout();
        test_sw_rst();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
